// File: rtl/debug_unit_pkg.sv
// Shared definitions for the UART debug controller: FSM state encoding,
// command bytes and the default halt instruction word.
package debug_unit_pkg;

    typedef enum logic [2:0] {
        ST_LOAD      = 3'd0,
        ST_WRITE     = 3'd1,
        ST_WAIT_CMD  = 3'd2,
        ST_RUN       = 3'd3,
        ST_STEP      = 3'd4,
        ST_SEND      = 3'd5,
        ST_STEP_WAIT = 3'd6,
        ST_DONE      = 3'd7
    } state_t;

    localparam logic [7:0]  CMD_CONT_DEF   = 8'h63;
    localparam logic [7:0]  CMD_STEP_DEF   = 8'h73;
    localparam logic [7:0]  CMD_RELOAD_DEF = 8'h72;
    localparam logic [31:0] HALT_WORD_DEF  = 32'hFFFF_FFFF;

endpackage

// File: rtl/debug_tx_serializer.sv
// Report serializer: loads a 2*LEN-bit report and sends it MSB byte first
// over the tx_start / tx_done handshake.
//   load      in   capture report, first tx_start follows next cycle
//   report    in   {pc, cycle count}
//   tx_done   in   transmitter finished current byte
//   tx_start  out  one-cycle pulse per byte
//   tx_data   out  current byte, held until the next byte is issued
//   done      out  high in the cycle the last byte's tx_done arrives
module debug_tx_serializer #(
    parameter int LEN = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [2*LEN-1:0] report,
    input  logic             tx_done,
    output logic             tx_start,
    output logic [7:0]       tx_data,
    output logic             done
);

    localparam int NBY = (2 * LEN) / 8;
    localparam int CW  = (NBY > 1) ? $clog2(NBY) : 1;

    logic [2*LEN-1:0] shreg;
    logic [CW-1:0]    remain;
    logic             busy;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            shreg    <= '0;
            remain   <= '0;
            busy     <= 1'b0;
            tx_start <= 1'b0;
            tx_data  <= '0;
        end else begin
            tx_start <= 1'b0;
            if (load) begin
                shreg    <= report << 8;
                tx_data  <= report[2*LEN-1 -: 8];
                tx_start <= 1'b1;
                busy     <= 1'b1;
                remain   <= CW'(NBY - 1);
            end else if (busy && tx_done) begin
                if (remain == '0) begin
                    busy <= 1'b0;
                end else begin
                    tx_data  <= shreg[2*LEN-1 -: 8];
                    shreg    <= shreg << 8;
                    remain   <= remain - 1'b1;
                    tx_start <= 1'b1;
                end
            end
        end
    end

    // Combinational so the FSM leaves SEND on the same edge that retires
    // the final byte.
    assign done = busy && tx_done && (remain == '0);

endmodule

// File: rtl/debug_unit.sv
// UART-side debug controller in front of the MIPS pipeline. Assembles
// program words from received bytes, writes them to instruction memory
// with the pipeline held in reset, then runs the pipeline continuously or
// one cycle per command and reports {pc, cycle count} over the UART.
//   clk, reset (async, active-low)
//   rx_done/rx_data     received byte
//   tx_done/tx_start/tx_data  transmit handshake
//   halt_in, pc_in      pipeline status
//   imem_we/imem_addr/imem_data  instruction-memory write port
//   cpu_enable, cpu_reset        pipeline control
//   state_o             current state for LEDs
//
// state      | meaning
// LOAD       | collecting program bytes, pipeline in reset
// WRITE      | one-cycle instruction-memory write
// WAIT_CMD   | program loaded, waiting for run/step command
// RUN        | pipeline enabled until halt
// STEP       | single enabled cycle
// SEND       | streaming pc/cycle report
// STEP_WAIT  | between steps, waiting for next command
// DONE       | halted, waiting for reload
module debug_unit
    import debug_unit_pkg::*;
#(
    parameter int              LEN        = 32,
    parameter int              ADDR_W     = 10,
    parameter logic [LEN-1:0]  HALT_WORD  = LEN'(HALT_WORD_DEF),
    parameter logic [7:0]      CMD_CONT   = CMD_CONT_DEF,
    parameter logic [7:0]      CMD_STEP   = CMD_STEP_DEF,
    parameter logic [7:0]      CMD_RELOAD = CMD_RELOAD_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              rx_done,
    input  logic [7:0]        rx_data,
    input  logic              tx_done,
    output logic              tx_start,
    output logic [7:0]        tx_data,
    input  logic              halt_in,
    input  logic [LEN-1:0]    pc_in,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [LEN-1:0]    imem_data,
    output logic              cpu_enable,
    output logic              cpu_reset,
    output logic [2:0]        state_o
);

    localparam int NB  = LEN / 8;
    localparam int BCW = (NB > 1) ? $clog2(NB) : 1;

    state_t          state, state_nx;
    logic [LEN-1:0]  word;
    logic [LEN-1:0]  cycle_cnt;
    logic [BCW-1:0]  byte_cnt;
    logic            step_mode;
    logic            halt_seen;
    logic            snap_pend;
    logic            ser_done;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= ST_LOAD;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx   = state;
        imem_we    = 1'b0;
        cpu_enable = 1'b0;
        cpu_reset  = 1'b0;
        case (state)
            ST_LOAD: begin
                cpu_reset = 1'b1;
                if (rx_done && byte_cnt == BCW'(NB - 1)) state_nx = ST_WRITE;
            end
            ST_WRITE: begin
                cpu_reset = 1'b1;
                imem_we   = 1'b1;
                state_nx  = (word == HALT_WORD) ? ST_WAIT_CMD : ST_LOAD;
            end
            ST_WAIT_CMD: begin
                if (rx_done && rx_data == CMD_CONT)      state_nx = ST_RUN;
                else if (rx_done && rx_data == CMD_STEP) state_nx = ST_STEP;
            end
            ST_RUN: begin
                cpu_enable = 1'b1;
                if (halt_in) state_nx = ST_SEND;
            end
            ST_STEP: begin
                cpu_enable = 1'b1;
                state_nx   = ST_SEND;
            end
            ST_SEND: begin
                if (ser_done) begin
                    if (halt_seen)      state_nx = ST_DONE;
                    else if (step_mode) state_nx = ST_STEP_WAIT;
                    else                state_nx = ST_DONE;
                end
            end
            ST_STEP_WAIT: begin
                if (rx_done && rx_data == CMD_STEP)      state_nx = ST_STEP;
                else if (rx_done && rx_data == CMD_CONT) state_nx = ST_RUN;
            end
            ST_DONE: begin
                if (rx_done && rx_data == CMD_RELOAD) state_nx = ST_LOAD;
            end
            default: state_nx = ST_LOAD;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            word      <= '0;
            byte_cnt  <= '0;
            imem_addr <= '0;
            cycle_cnt <= '0;
            step_mode <= 1'b0;
            halt_seen <= 1'b0;
            snap_pend <= 1'b0;
        end else begin
            // Report capture happens in the first SEND cycle, once the
            // pipeline is stopped and cycle_cnt holds its final value.
            snap_pend <= (state_nx == ST_SEND) && (state != ST_SEND);
            case (state)
                ST_LOAD: begin
                    if (rx_done) begin
                        word     <= (word << 8) | LEN'(rx_data);
                        byte_cnt <= byte_cnt + 1'b1;
                    end
                end
                ST_WRITE: begin
                    imem_addr <= imem_addr + 1'b1;
                    byte_cnt  <= '0;
                end
                ST_WAIT_CMD: begin
                    if (rx_done && rx_data == CMD_STEP) step_mode <= 1'b1;
                end
                ST_RUN, ST_STEP: begin
                    cycle_cnt <= cycle_cnt + 1'b1;
                    halt_seen <= halt_in;
                end
                ST_STEP_WAIT: begin
                    if (rx_done && rx_data == CMD_CONT) step_mode <= 1'b0;
                end
                ST_DONE: begin
                    if (rx_done && rx_data == CMD_RELOAD) begin
                        word      <= '0;
                        byte_cnt  <= '0;
                        imem_addr <= '0;
                        cycle_cnt <= '0;
                        step_mode <= 1'b0;
                        halt_seen <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    debug_tx_serializer #(.LEN(LEN)) u_ser (
        .clk      (clk),
        .reset    (reset),
        .load     (snap_pend),
        .report   ({pc_in, cycle_cnt}),
        .tx_done  (tx_done),
        .tx_start (tx_start),
        .tx_data  (tx_data),
        .done     (ser_done)
    );

    assign imem_data = word;
    assign state_o   = state;

endmodule
